dvi_link_ctrl: RTL and testbench

- Pixel-clock-domain sequencer that feeds the three 10-bit TMDS symbol inputs of the DVI serializer.
- Generates raster timing and requests encoded pixel symbols from upstream.
- Inserts DVI control tokens during blanking.
- Runs a link bring-up state machine so the sink locks on blank frames before video is released.

---
 rtl/dvi_link_ctrl.sv | 130 +++++++++++++
 tb/tb_dvi_link_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dvi_link_ctrl.sv
// dvi_link_ctrl: raster timing, DVI control tokens and link bring-up sequencing for a TMDS serializer
// Define DVI_LINK_CTRL_UNDERRUN_CNT_EN to add the saturating underrun_count output.
module dvi_link_ctrl #(
    parameter int H_ACTIVE       = 720,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 62,
    parameter int H_BP           = 60,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 9,
    parameter int V_SYNC         = 6,
    parameter int V_BP           = 30,
    parameter int SYNC_POL       = 0,
    parameter int STARTUP_FRAMES = 4
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic        enable,
    output logic        pixel_req,
    input  logic        enc_valid,
    input  logic [9:0]  enc0,
    input  logic [9:0]  enc1,
    input  logic [9:0]  enc2,
    output logic [9:0]  tmds_internal0,
    output logic [9:0]  tmds_internal1,
    output logic [9:0]  tmds_internal2,
    output logic        frame_start,
    output logic        video_on,
`ifdef DVI_LINK_CTRL_UNDERRUN_CNT_EN
    output logic [15:0] underrun_count,
`endif
    output logic        underrun
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [7:0] SF = 8'(STARTUP_FRAMES);
    localparam logic INV = SYNC_POL == 0;
    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] TOK11 = 10'b1010101011;
    localparam logic [9:0] BLACK = 10'b0100000000;

    typedef enum logic [1:0] {RESET, IDLE, WARMUP, ACTIVE} state_t;

    state_t        state, st_nxt;
    logic [HW-1:0] hcnt, h_nxt;
    logic [VW-1:0] vcnt, v_nxt;
    logic [7:0]    fcnt, f_nxt;
    logic          fs_nxt, act_nxt, req_d, miss;
    logic [1:0]    ctl, ctl_d;

    function automatic logic [9:0] tok(input logic [1:0] c);
        return c == 2'b00 ? TOK00 : c == 2'b01 ? TOK01 : c == 2'b10 ? TOK10 : TOK11;
    endfunction

    // Everything registered below is derived from the next position, so the
    // state change, frame_start and the first pixel_req of a frame coincide.
    always_comb begin
        h_nxt = (state == RESET || hcnt == H_LAST) ? '0 : hcnt + 1'b1;
        v_nxt = state == RESET ? '0 : hcnt != H_LAST ? vcnt : vcnt == V_LAST ? '0 : vcnt + 1'b1;
        fs_nxt = h_nxt == '0 && v_nxt == '0;
        act_nxt = h_nxt < H_ACT && v_nxt < V_ACT;
        ctl = {(vcnt >= V_SS && vcnt < V_SE) ^ INV, (hcnt >= H_SS && hcnt < H_SE) ^ INV};
        miss = req_d && !enc_valid;
        st_nxt = state;
        f_nxt = fcnt;
        if (state == RESET || (state == WARMUP && !enable)) begin
            st_nxt = IDLE;
        end else if (fs_nxt && state == IDLE && enable) begin
            st_nxt = WARMUP;
            f_nxt = '0;
        end else if (fs_nxt && state == WARMUP) begin
            f_nxt = fcnt + 8'd1;
            st_nxt = f_nxt == SF ? ACTIVE : WARMUP;
        end else if (fs_nxt && state == ACTIVE && !enable) begin
            st_nxt = IDLE;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RESET;
            hcnt           <= '0;
            vcnt           <= '0;
            fcnt           <= '0;
            frame_start    <= 1'b0;
            video_on       <= 1'b0;
            pixel_req      <= 1'b0;
            req_d          <= 1'b0;
            ctl_d          <= 2'b00;
            tmds_internal0 <= TOK00;
            tmds_internal1 <= TOK00;
            tmds_internal2 <= TOK00;
            underrun       <= 1'b0;
        end else begin
            state          <= st_nxt;
            hcnt           <= h_nxt;
            vcnt           <= v_nxt;
            fcnt           <= f_nxt;
            frame_start    <= fs_nxt;
            video_on       <= st_nxt == ACTIVE;
            pixel_req      <= act_nxt && st_nxt == ACTIVE;
            req_d          <= pixel_req;
            ctl_d          <= state == RESET ? 2'b00 : ctl;
            tmds_internal0 <= req_d ? (enc_valid ? enc0 : BLACK) : tok(ctl_d);
            tmds_internal1 <= req_d ? (enc_valid ? enc1 : BLACK) : TOK00;
            tmds_internal2 <= req_d ? (enc_valid ? enc2 : BLACK) : TOK00;
            underrun       <= st_nxt == ACTIVE && (underrun || miss);
        end
    end

`ifdef DVI_LINK_CTRL_UNDERRUN_CNT_EN
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n)
            underrun_count <= '0;
        else
            underrun_count <= underrun_count + {15'd0, miss && underrun_count != 16'hFFFF};
    end
`endif
endmodule

// File: tb/tb_dvi_link_ctrl.sv
// tb_dvi_link_ctrl: scoreboard bench for dvi_link_ctrl on a 14x7 raster with two warm-up frames
module tb_dvi_link_ctrl;
    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] TOK11 = 10'b1010101011;
    localparam logic [9:0] BLACK = 10'b0100000000;

    typedef struct {
        logic [9:0] s0;
        logic [9:0] s1;
        logic [9:0] s2;
        logic       dr;
    } ent_t;

    logic       clk_pixel = 1'b0;
    logic       reset_n, enable, enc_valid;
    logic [9:0] enc0, enc1, enc2;
    logic       pixel_req, frame_start, video_on, underrun;
    logic [9:0] tmds_internal0, tmds_internal1, tmds_internal2;
`ifdef DVI_LINK_CTRL_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif
    int         n_assert, n_fail, h, v;
    logic       vid_exp, und_exp, use_rand, drop_one, pend_v;
    logic [9:0] pend0, pend1, pend2;
    ent_t       sb[$];

    dvi_link_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(0), .STARTUP_FRAMES(2)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset_n(reset_n),
        .enable(enable),
        .pixel_req(pixel_req),
        .enc_valid(enc_valid),
        .enc0(enc0),
        .enc1(enc1),
        .enc2(enc2),
        .tmds_internal0(tmds_internal0),
        .tmds_internal1(tmds_internal1),
        .tmds_internal2(tmds_internal2),
        .frame_start(frame_start),
        .video_on(video_on),
`ifdef DVI_LINK_CTRL_UNDERRUN_CNT_EN
        .underrun_count(underrun_count),
`endif
        .underrun(underrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h at h=%0d v=%0d", tag, obs, exp, h, v);
        end
    endtask

    // Blanking token on ch0: syncs are active-low on the wire, {c1,c0} = {vsync,hsync}.
    function automatic logic [9:0] blank_tok(input int hh, input int vv);
        logic [1:0] c;
        c = {vv != 5, !(hh == 10 || hh == 11)};
        case (c)
            2'b00:   return TOK00;
            2'b01:   return TOK01;
            2'b10:   return TOK10;
            default: return TOK11;
        endcase
    endfunction

    task automatic preload();
        ent_t e;
        sb.delete();
        e.s0 = TOK00;
        e.s1 = TOK00;
        e.s2 = TOK00;
        e.dr = 1'b0;
        sb.push_back(e);
        sb.push_back(e);
    endtask

    task automatic cyc();
        ent_t e;
        logic ereq, dr;
        logic [9:0] d0, d1, d2;
        @(negedge clk_pixel);
        enc_valid = pend_v;
        enc0 = pend0;
        enc1 = pend1;
        enc2 = pend2;
        ereq = vid_exp && h < 8 && v < 4;
        chk("pixel_req", pixel_req, ereq);
        chk("frame_start", frame_start, h == 0 && v == 0);
        chk("video_on", video_on, vid_exp);
        dr = ereq && drop_one && h == 3 && v == 1;
        if (dr) drop_one = 1'b0;
        d0 = use_rand ? 10'($urandom_range(0, 1023)) : 10'h155;
        d1 = use_rand ? 10'($urandom_range(0, 1023)) : 10'h2AA;
        d2 = use_rand ? 10'($urandom_range(0, 1023)) : 10'h0F0;
        pend_v = ereq && !dr;
        pend0 = d0;
        pend1 = d1;
        pend2 = d2;
        if (ereq) begin
            e.s0 = dr ? BLACK : d0;
            e.s1 = dr ? BLACK : d1;
            e.s2 = dr ? BLACK : d2;
        end else begin
            e.s0 = blank_tok(h, v);
            e.s1 = TOK00;
            e.s2 = TOK00;
        end
        e.dr = dr;
        sb.push_back(e);
        e = sb.pop_front();
        if (e.dr) und_exp = 1'b1;
        chk("tmds0", tmds_internal0, e.s0);
        chk("tmds1", tmds_internal1, e.s1);
        chk("tmds2", tmds_internal2, e.s2);
        chk("underrun", underrun, und_exp);
        h = h == 13 ? 0 : h + 1;
        if (h == 0) v = v == 6 ? 0 : v + 1;
    endtask

    task automatic run_frames(input int n);
        repeat (n) begin
            cyc();
            while (h != 0 || v != 0) cyc();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pixel_req"}, pixel_req, 1'b0);
        chk({tag, "_frame_start"}, frame_start, 1'b0);
        chk({tag, "_video_on"}, video_on, 1'b0);
        chk({tag, "_underrun"}, underrun, 1'b0);
        chk({tag, "_tmds0"}, tmds_internal0, TOK00);
        chk({tag, "_tmds1"}, tmds_internal1, TOK00);
        chk({tag, "_tmds2"}, tmds_internal2, TOK00);
`ifdef DVI_LINK_CTRL_UNDERRUN_CNT_EN
        chk({tag, "_underrun_count"}, underrun_count, 16'd0);
`endif
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        h = 0;
        v = 0;
        reset_n = 1'b0;
        enable = 1'b0;
        enc_valid = 1'b0;
        enc0 = '0;
        enc1 = '0;
        enc2 = '0;
        pend_v = 1'b0;
        pend0 = '0;
        pend1 = '0;
        pend2 = '0;
        vid_exp = 1'b0;
        und_exp = 1'b0;
        use_rand = 1'b0;
        drop_one = 1'b0;
        repeat (3) @(negedge clk_pixel);
        chk_reset_vals("reset");
        reset_n = 1'b1;
        preload();
        run_frames(2);
        repeat (40) cyc();
        enable = 1'b1;
        run_frames(3);
        vid_exp = 1'b1;
        run_frames(1);
        use_rand = 1'b1;
        drop_one = 1'b1;
        run_frames(1);
`ifdef DVI_LINK_CTRL_UNDERRUN_CNT_EN
        chk("underrun_count", underrun_count, 16'd1);
`endif
        repeat (20) cyc();
        enable = 1'b0;
        run_frames(1);
        vid_exp = 1'b0;
        und_exp = 1'b0;
        run_frames(1);
        repeat (30) cyc();
        enable = 1'b1;
        run_frames(3);
        vid_exp = 1'b1;
        repeat (18) cyc();
        #1 reset_n = 1'b0;
        #1 chk_reset_vals("async");
        enable = 1'b0;
        repeat (2) @(negedge clk_pixel);
        reset_n = 1'b1;
        h = 0;
        v = 0;
        vid_exp = 1'b0;
        und_exp = 1'b0;
        pend_v = 1'b0;
        preload();
        run_frames(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
